// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM initiator that copies a block of 32-bit words from src to dst, or
// fills dst with a constant. It issues one transaction at a time.
module avalon_mm_copy_master #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [31:0]       fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;
  logic              mode_q, mode_d;
  logic              aborted_q, aborted_d;
  logic [31:0]       wdata_q, wdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      words_done_q <= '0;
      mode_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      words_done_q <= words_done_d;
      mode_q       <= mode_d;
      aborted_q    <= aborted_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    words_done_d = words_done_q;
    mode_d       = mode_q;
    aborted_d    = aborted_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d        = {src_addr[ADDR_W-1:2], 2'b00};
          dst_d        = {dst_addr[ADDR_W-1:2], 2'b00};
          rem_d        = len_words;
          mode_d       = mode;
          words_done_d = '0;
          aborted_d    = 1'b0;
          // Fill data goes straight into the write-data register and stays there.
          if (mode) begin
            wdata_d = fill_value;
          end
          if (len_words == '0) begin
            state_d = S_DONE;
          end else if (mode) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (!m_waitrequest) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (m_readdatavalid) begin
          wdata_d = m_readdata;
          state_d = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (!m_waitrequest) begin
          words_done_d = words_done_q + ONE_WORD;
          rem_d        = rem_q - ONE_WORD;
          src_d        = src_q + WORD_STEP;
          dst_d        = dst_q + WORD_STEP;
          // aborted only flags an operation that abort actually cut short.
          if (rem_q == ONE_WORD || abort) begin
            aborted_d = abort && (rem_q != ONE_WORD);
            state_d   = S_DONE;
          end else if (mode_q) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign aborted      = aborted_q;
  assign words_done   = words_done_q;
  assign m_read       = (state_q == S_RD_REQ);
  assign m_write      = (state_q == S_WR_REQ);
  assign m_address    = (state_q == S_RD_REQ) ? src_q : dst_q;
  assign m_byteenable = '1;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_mm_copy_master.sv
// Directed bench for avalon_mm_copy_master with a RAM slave model that can
// stall with waitrequest and return read data after a programmable latency.
module tb_avalon_mm_copy_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [13:0] src_addr;
  logic [13:0] dst_addr;
  logic [12:0] len_words;
  logic [31:0] fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [12:0] words_done;
  logic [13:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_waitrequest;

  avalon_mm_copy_master #(
    .ADDR_W(14),
    .LEN_W (13)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len_words      (len_words),
    .fill_value     (fill_value),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .words_done     (words_done),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_byteenable   (m_byteenable),
    .m_writedata    (m_writedata),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_waitrequest  (m_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model state
  logic [31:0] mem [0:4095];
  logic [13:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  logic [13:0] rd_addr_q [$];
  int          wait_max   = 0;
  int          lat_min    = 1;
  int          lat_max    = 1;
  int          wcnt       = 0;
  bit          force_wait = 1'b0;
  int          rd_cnt     = 0;
  logic [31:0] rd_data    = '0;
  bit          stall_q    = 1'b0;
  logic        sv_rd, sv_wr;
  logic [13:0] sv_addr;
  logic [31:0] sv_data;

  // Slave decides waitrequest/readdatavalid at the negedge before the DUT samples them.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q         = 1'b0;
      rd_cnt          = 0;
      m_readdatavalid = 1'b0;
      m_waitrequest   = 1'b0;
    end else begin
      m_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata      = rd_data;
        end
      end
      chk("no_overlap", 32'(m_read & m_write), 32'd0);
      if (stall_q) begin
        chk("stall_cmd", {30'd0, m_read, m_write}, {30'd0, sv_rd, sv_wr});
        chk("stall_addr", 32'(m_address), 32'(sv_addr));
        chk("stall_data", m_writedata, sv_data);
      end
      stall_q = 1'b0;
      if (m_read || m_write) begin
        if (force_wait || wcnt > 0) begin
          m_waitrequest = 1'b1;
          if (!force_wait) wcnt--;
          stall_q = 1'b1;
          sv_rd   = m_read;
          sv_wr   = m_write;
          sv_addr = m_address;
          sv_data = m_writedata;
        end else begin
          m_waitrequest = 1'b0;
          if (m_read) begin
            rd_addr_q.push_back(m_address);
            rd_data = mem[m_address[13:2]];
            rd_cnt  = int'($urandom_range(lat_max, lat_min));
          end else begin
            mem[m_address[13:2]] = m_writedata;
            wr_addr_q.push_back(m_address);
            wr_data_q.push_back(m_writedata);
            wr_cyc_q.push_back(cyc);
          end
          wcnt = int'($urandom_range(wait_max, 0));
        end
      end else begin
        m_waitrequest = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic do_start(input logic md, input logic [13:0] s, input logic [13:0] d,
                          input logic [12:0] l, input logic [31:0] f);
    @(negedge clk);
    mode       = md;
    src_addr   = s;
    dst_addr   = d;
    len_words  = l;
    fill_value = f;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n    = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len_words  = '0;
    fill_value = '0;
    abort      = 1'b0;
    m_readdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset values
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_cmd", {30'd0, m_read, m_write}, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_address", 32'(m_address), 32'd0);
    chk("rst_writedata", m_writedata, 32'd0);
    chk("rst_byteenable", 32'(m_byteenable), 32'hF);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    // Fill, zero-wait: four consecutive write beats
    clear_logs();
    do_start(1'b1, 14'h0000, 14'h0100, 13'd4, 32'hDEADBEEF);
    chk("fill_busy", 32'(busy), 32'd1);
    wait_done(50);
    chk("fill_words_done", 32'(words_done), 32'd4);
    chk("fill_aborted", 32'(aborted), 32'd0);
    chk("fill_nwr", 32'(wr_addr_q.size()), 32'd4);
    chk("fill_nrd", 32'(rd_addr_q.size()), 32'd0);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk("fill_addr", 32'(wr_addr_q[i]), 32'h100 + 32'(4 * i));
      chk("fill_data", wr_data_q[i], 32'hDEADBEEF);
      chk("fill_cycle", 32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
    end
    @(negedge clk);
    chk("fill_done_pulse", 32'(done), 32'd0);
    chk("fill_busy_end", 32'(busy), 32'd0);

    // len=0: done one cycle after start, no bus traffic
    clear_logs();
    do_start(1'b0, 14'h0010, 14'h0020, 13'd0, 32'h0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_cmd", {30'd0, m_read, m_write}, 32'd0);
    @(negedge clk);
    chk("len0_done_end", 32'(done), 32'd0);
    chk("len0_busy_end", 32'(busy), 32'd0);
    chk("len0_traffic", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'd0);
    chk("len0_words_done", 32'(words_done), 32'd0);

    // Copy with latency-1 RAM, zero wait: 3 cycles per word
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    clear_logs();
    do_start(1'b0, 14'h0000, 14'h2000, 13'd4, 32'h0);
    wait_done(100);
    chk("copy_words_done", 32'(words_done), 32'd4);
    chk("copy_nrd", 32'(rd_addr_q.size()), 32'd4);
    chk("copy_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("copy_mem", mem[12'h800 + i], 32'h11111111 * 32'(i + 1));
      if (i < rd_addr_q.size()) chk("copy_rd_addr", 32'(rd_addr_q[i]), 32'(4 * i));
      if (i < wr_addr_q.size()) chk("copy_wr_addr", 32'(wr_addr_q[i]), 32'h2000 + 32'(4 * i));
      if (i > 0 && i < wr_cyc_q.size()) chk("copy_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd3);
    end

    // Waitrequest / latency stress, copy 16 words
    for (int i = 0; i < 16; i++) mem[12'h100 + i] = 32'hC0DE0000 + 32'(i);
    wait_max = 5;
    lat_min  = 1;
    lat_max  = 4;
    wcnt     = 3;
    clear_logs();
    do_start(1'b0, 14'h0400, 14'h1000, 13'd16, 32'h0);
    wait_done(2000);
    chk("stress_words_done", 32'(words_done), 32'd16);
    for (int i = 0; i < 16; i++) chk("stress_mem", mem[12'h400 + i], 32'hC0DE0000 + 32'(i));
    wait_max = 0;
    lat_max  = 1;
    wcnt     = 0;
    @(negedge clk);

    // Fill wrapping at the top of the window
    clear_logs();
    do_start(1'b1, 14'h0000, 14'h3FF8, 13'd3, 32'hA5A5A5A5);
    wait_done(50);
    chk("wrap_nwr", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      chk("wrap_addr0", 32'(wr_addr_q[0]), 32'h3FF8);
      chk("wrap_addr1", 32'(wr_addr_q[1]), 32'h3FFC);
      chk("wrap_addr2", 32'(wr_addr_q[2]), 32'h0000);
    end
    chk("wrap_mem0", mem[0], 32'hA5A5A5A5);

    // Unaligned addresses are word-aligned
    mem[12'h040] = 32'h600DF00D;
    clear_logs();
    do_start(1'b0, 14'h0103, 14'h0203, 13'd1, 32'h0);
    wait_done(50);
    chk("unal_nrd", 32'(rd_addr_q.size()), 32'd1);
    if (rd_addr_q.size() > 0) chk("unal_rd_addr", 32'(rd_addr_q[0]), 32'h0100);
    if (wr_addr_q.size() > 0) chk("unal_wr_addr", 32'(wr_addr_q[0]), 32'h0200);
    chk("unal_mem", mem[12'h080], 32'h600DF00D);

    // Abort during word 3's read; a start while busy is ignored
    for (int i = 0; i < 10; i++) mem[12'h200 + i] = 32'hAB000000 + 32'(i);
    clear_logs();
    do_start(1'b0, 14'h0800, 14'h0C00, 13'd10, 32'h0);
    mode       = 1'b1;
    dst_addr   = 14'h0E00;
    len_words  = 13'd5;
    fill_value = 32'hBAD0BAD0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (wr_addr_q.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    while (m_read !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_in_read", 32'(m_read), 32'd1);
    abort = 1'b1;
    wait_done(100);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_words_done", 32'(words_done), 32'd3);
    chk("abort_nwr", 32'(wr_addr_q.size()), 32'd3);
    chk("abort_word3", mem[12'h302], 32'hAB000002);
    chk("abort_word4", mem[12'h303], 32'h0);
    chk("ignored_start", mem[12'h380], 32'h0);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_end", 32'(busy), 32'd0);
    do_start(1'b0, 14'h0000, 14'h0000, 13'd0, 32'h0);
    chk("aborted_cleared", 32'(aborted), 32'd0);

    // Async reset while a write is stalled
    force_wait = 1'b1;
    clear_logs();
    do_start(1'b1, 14'h0000, 14'h0300, 13'd2, 32'h12345678);
    chk("rstmid_write", 32'(m_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_write_drop", 32'(m_write), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_words_done", 32'(words_done), 32'd0);
    chk("rstmid_address", 32'(m_address), 32'd0);
    force_wait = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    do_start(1'b1, 14'h0000, 14'h0300, 13'd2, 32'h12345678);
    wait_done(50);
    chk("rstmid_restart_words", 32'(words_done), 32'd2);
    chk("rstmid_mem0", mem[12'h0C0], 32'h12345678);
    chk("rstmid_mem1", mem[12'h0C1], 32'h12345678);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
